// File: rtl/aes128_pkg.sv
// Shared AES-128 constants, FSM state type and the byte/column/key-schedule
// helpers used by the round logic. State byte 0 is bits [127:120], column-major.
package aes128_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column word carries row 0 in its most significant byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = SBOX[s[8*i +: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] rk, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = rk;
        t  = {SBOX[w3[23:16]] ^ rcon, SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes128_enc_stream_if.sv
// Valid/ready block interface between plaintext source, AES engine and ciphertext sink.
// With AES128_ENC_CBC_EN defined it also carries the CBC iv and first-block flag.
interface aes128_enc_stream_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] key;
    logic [127:0] plain_text;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] cipher_text;
`ifdef AES128_ENC_CBC_EN
    logic [127:0] iv;
    logic         first;

    modport master (
        output in_valid, key, plain_text, iv, first, out_ready,
        input  in_ready, out_valid, cipher_text
    );
    modport slave (
        input  in_valid, key, plain_text, iv, first, out_ready,
        output in_ready, out_valid, cipher_text
    );
`else
    modport master (
        output in_valid, key, plain_text, out_ready,
        input  in_ready, out_valid, cipher_text
    );
    modport slave (
        input  in_valid, key, plain_text, out_ready,
        output in_ready, out_valid, cipher_text
    );
`endif

endinterface

// File: rtl/aes128_round.sv
// One combinational AES-128 encryption round plus the matching key-schedule step.
// MixColumns is bypassed when last_i marks the final round.
module aes128_round
    import aes128_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic [7:0]   rcon_i,
    input  logic         last_i,
    output logic [127:0] state_o,
    output logic [127:0] rk_o,
    output logic [7:0]   rcon_o
);

    logic [127:0] sr;
    logic [127:0] mc;

    always_comb begin
        sr = shift_rows(sub_bytes(state_i));
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[32*c +: 32] = mix_column(sr[32*c +: 32]);
        end
    end

    assign rk_o    = key_step(rk_i, rcon_i);
    assign rcon_o  = xtime(rcon_i);
    assign state_o = (last_i ? sr : mc) ^ rk_o;

endmodule

// File: rtl/aes128_enc_stream.sv
// Iterative AES-128 encryptor, UNROLL rounds per clock, on-the-fly key schedule.
// Define AES128_ENC_CBC_EN to add CBC chaining (iv/first on the bus, chain register).
module aes128_enc_stream
    import aes128_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    aes128_enc_stream_if.slave  bus,
    output logic                busy
);

    localparam int LAT = NR / UNROLL;

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes128_enc_stream: UNROLL must be 1, 2, 5 or 10");
    end

    aes_state_e   state_q, state_d;
    logic         rdy_q;
    logic [3:0]   rnd_q;
    logic [127:0] st_q;
    logic [127:0] rk_q;
    logic [7:0]   rcon_q;
    logic [127:0] ct_q;

    logic         accept;
    logic         out_hs;
    logic         last_step;
    logic [127:0] whiten;

    logic [127:0] s_ch [UNROLL+1];
    logic [127:0] k_ch [UNROLL+1];
    logic [7:0]   c_ch [UNROLL+1];

    assign accept    = bus.in_valid && bus.in_ready;
    assign out_hs    = bus.out_valid && bus.out_ready;
    assign last_step = (rnd_q == 4'(UNROLL * (LAT - 1)));

`ifdef AES128_ENC_CBC_EN
    logic [127:0] chain_q;
    logic [127:0] chain_sel;

    // An accept in DONE coincides with the output handshake, so chain from the
    // ciphertext leaving this cycle rather than the not-yet-updated register.
    assign chain_sel = bus.first ? bus.iv : ((state_q == DONE) ? ct_q : chain_q);
    assign whiten    = bus.plain_text ^ chain_sel ^ bus.key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else if (out_hs) begin
            chain_q <= ct_q;
        end
    end
`else
    assign whiten = bus.plain_text ^ bus.key;
`endif

    assign s_ch[0] = st_q;
    assign k_ch[0] = rk_q;
    assign c_ch[0] = rcon_q;

    for (genvar j = 0; j < UNROLL; j++) begin : g_round
        aes128_round u_round (
            .state_i (s_ch[j]),
            .rk_i    (k_ch[j]),
            .rcon_i  (c_ch[j]),
            .last_i  (rnd_q == 4'(NR - 1 - j)),
            .state_o (s_ch[j+1]),
            .rk_o    (k_ch[j+1]),
            .rcon_o  (c_ch[j+1])
        );
    end

    // rdy_q keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = accept ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state_q)
            IDLE:    bus.in_ready = rdy_q;
            BUSY:    busy = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_q <= '0;
            ct_q  <= '0;
        end else begin
            if (accept) begin
                rnd_q <= '0;
            end else if (state_q == BUSY) begin
                rnd_q <= rnd_q + 4'(UNROLL);
            end
            if (state_q == BUSY && last_step) begin
                ct_q <= s_ch[UNROLL];
            end
        end
    end

    // Round datapath: whitening on accept, UNROLL rounds per BUSY edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            st_q   <= whiten;
            rk_q   <= bus.key;
            rcon_q <= 8'h01;
        end else if (state_q == BUSY) begin
            st_q   <= s_ch[UNROLL];
            rk_q   <= k_ch[UNROLL];
            rcon_q <= c_ch[UNROLL];
        end
    end

    assign bus.cipher_text = ct_q;

endmodule
